esl_pe_vector: RTL and testbench
================================

# esl_pe_vector

Parametrised, multi-lane successor to the single-lane ESL processing element. Each of `LANES` lanes holds a binary weight and converts it to a bitstream with a shared LFSR-driven SNG. It multiplies that stream against an incoming ESL (x, y) stream pair and optionally scale-adds an init stream pair. A start/done FSM frames exactly one full LFSR period, and per-lane ones-counters convert the output streams back to binary. The block sits in the systolic datapath between the activation stream feeders and the binary readout logic.

## Interface
Parameters:
- `LANES`, 4, number of independent lanes (1..32)
- `BIN_LEN`, 8, weight width and LFSR width (3..16); stream length `L = 2^BIN_LEN - 1`
- `SEED`, 1, LFSR reset value; nonzero

Ports:
- `clock`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  advances all run-time state when high; freezes it when low.
- `weight_valid`  in  1  weight load request.
- `weight_ready`  out  1  high when a weight load is accepted.
- `weight_val`  in  LANES*BIN_LEN  lane i weight in bits [i*BIN_LEN +: BIN_LEN].
- `add_en`  in  1  1 = scaled add with init stream; 0 = product only. Sampled at start.
- `start`  in  1  single-cycle pulse that begins a run.
- `input_val_x`, `input_val_y`  in  LANES  per-lane input stream bits.
- `init_val_x`, `init_val_y`  in  LANES  per-lane init stream bits.
- `output_val_x`, `output_val_y`  out  LANES  registered output stream bits.
- `out_valid`  out  1  output stream registers hold run data.
- `busy`  out  1  FSM in RUN.
- `done`  out  1  FSM in DONE; counts valid.
- `cnt_x`, `cnt_y`  out  LANES*BIN_LEN  per-lane ones counts.

## Operation
- FSM states and transitions:
  - IDLE: `start` → RUN.
  - RUN: after L enabled cycles → DONE.
  - DONE: `start` → RUN. Otherwise holds indefinitely.
- `start` is ignored in RUN.
- `weight_ready = !busy`. A weight load happens when `weight_valid && weight_ready`; all lanes load in one cycle. `weight_valid` in RUN is ignored and is not queued.
- LFSR: Fibonacci, maximal-length, `BIN_LEN` bits. It visits each value 1..L exactly once per period.
  - Reloaded to `SEED` on `start`.
  - Steps once per enabled RUN cycle.
- Lane i SNG bit: `w_i = (rotl(lfsr, i mod BIN_LEN) <= weight_i)`. Over one run this gives exactly `weight_i` ones per lane.
- Product: `p_x = w_i & input_val_x[i]`; `p_y = input_val_y[i]`. The weight's y-stream is constant 1.
- Select flop `sel`:
  - Cleared on `start`; toggles every enabled RUN cycle.
  - With `add_en` = 1: `sel` = 0 picks the product pair, `sel` = 1 picks the init pair. Over L cycles the product is picked (L+1)/2 times and init (L-1)/2 times.
  - With `add_en` = 0: the product is always picked.
- Output registers capture the selected pair on every enabled RUN cycle. They hold their value otherwise.
- Counters:
  - Cleared on `start`.
  - Each lane's counters add the bits being registered on the same edge.
  - Width `BIN_LEN`; the maximum value L is reached without overflow.
  - Held through DONE and IDLE until the next `start`.

## Timing
- Reset values:
  - state IDLE, `lfsr` = `SEED`, `sel` = 0, weights 0.
  - All outputs 0, except `weight_ready` = 1.
- RUN lasts exactly L cycles with `enable` high. Enable-low cycles stretch RUN and change no state.
- Inputs sampled in RUN cycle k appear on `output_val_*` in cycle k+1. `out_valid` is high on cycles 1..L after `start` (enable-high case) and low in IDLE.
- `done` rises on the cycle after the L-th sample edge. Counts are final in that same cycle.
- `start` in DONE clears the counts and `done` on the next edge.
- Simultaneous `start` and `weight_valid` in IDLE/DONE: the weight loads, and the run uses the new weight.
- Reset asserted mid-run: immediate return to reset values. No partial counts are retained.

## Configuration
- `ESL_PE_COUNT_EN` defined: the per-lane counters are built, and `cnt_x`/`cnt_y` behave as above.
- `ESL_PE_COUNT_EN` undefined: no counters are built and `cnt_x`/`cnt_y` are tied to 0. Streams, FSM and `done` timing are unchanged.

## Test plan
All scenarios use `BIN_LEN` = 4 (L = 15), `LANES` = 4 and `ESL_PE_COUNT_EN` defined.
- Weight 15 on all lanes, input (1,1), init (0,0), `add_en` = 1, start → `done` exactly 16 cycles after start; `cnt_x` = 8 and `cnt_y` = 8 per lane.
- Weight 0, input (1,1), init (1,1), `add_en` = 1 → `cnt_x` = 7, `cnt_y` = 15.
- Weights {5,0,9,15}, input (1,1), `add_en` = 0 → `cnt_x` = {5,0,9,15}, `cnt_y` = 15 on all lanes.
- Scenario 3 with `enable` low for 3 mid-run cycles → same counts; `done` 3 cycles later; outputs frozen during the stall.
- `reset` asserted at RUN cycle 7, then released, then `weight_valid` pulsed during the next run → counts 0 and `weight_ready` = 1 right after reset; the RUN-time load is ignored and the old weights are used.
- Back-to-back: `start` in the first DONE cycle → counters clear, `done` falls, and the second run reproduces identical counts.

Source files
------------

// File: rtl/esl_pe_vector.sv
`default_nettype none
// ============================================================================
// Module   : esl_pe_vector
// Purpose  : Multi-lane ESL processing element. Each lane converts a binary
//            weight into a bitstream with a shared LFSR-driven SNG. It
//            multiplies that stream with an incoming ESL (x, y) pair and can
//            scale-add an init pair. A start/done FSM frames one full LFSR
//            period. Optional per-lane ones-counters read the streams back
//            as binary values.
// Revision : 1.0 - initial release
// Config   : ESL_PE_COUNT_EN - when defined, builds the per-lane counters.
//            When undefined, cnt_x/cnt_y are tied to 0.
// Ports    : clock, reset (async, active-low), enable (global advance)
//            weight_valid/weight_ready/weight_val - all-lane weight load
//            add_en, start            - run control, both sampled at start
//            input_val_x/y, init_val_x/y - per-lane stream inputs
//            output_val_x/y, out_valid   - registered per-lane stream outputs
//            busy, done                  - FSM in RUN / DONE
//            cnt_x, cnt_y                - per-lane ones counts
// LFSR     : Fibonacci, shift toward MSB, feedback into bit 0 is the XOR of
//            the tapped bits (e.g. x^4+x^3+1 for BIN_LEN = 4).
// ============================================================================
module esl_pe_vector #(
  parameter int LANES   = 4,
  parameter int BIN_LEN = 8,
  parameter int SEED    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     weight_valid,
  output logic                     weight_ready,
  input  logic [LANES*BIN_LEN-1:0] weight_val,
  input  logic                     add_en,
  input  logic                     start,
  input  logic [LANES-1:0]         input_val_x,
  input  logic [LANES-1:0]         input_val_y,
  input  logic [LANES-1:0]         init_val_x,
  input  logic [LANES-1:0]         init_val_y,
  output logic [LANES-1:0]         output_val_x,
  output logic [LANES-1:0]         output_val_y,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*BIN_LEN-1:0] cnt_x,
  output logic [LANES*BIN_LEN-1:0] cnt_y
);

  // Maximal-length tap masks, bit (t-1) set for tap t.
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]        C_TAP_ALL = tap_mask(BIN_LEN);
  localparam logic [BIN_LEN-1:0] C_TAPS    = C_TAP_ALL[BIN_LEN-1:0];
  localparam logic [BIN_LEN-1:0] C_SEED    = SEED[BIN_LEN-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                     state_q;
  logic [BIN_LEN-1:0]         lfsr_q;
  logic [BIN_LEN-1:0]         lfsr_d;
  logic                       sel_q;
  logic                       add_en_q;
  logic                       out_valid_q;
  logic [LANES*BIN_LEN-1:0]   weight_q;
  logic                       w_start;
  logic                       w_step;
  logic                       w_use_init;

  // start is ignored while a run is in progress.
  assign w_start    = enable & start & (state_q != S_RUN);
  assign w_step     = enable & (state_q == S_RUN);
  assign lfsr_d     = {lfsr_q[BIN_LEN-2:0], ^(lfsr_q & C_TAPS)};
  assign w_use_init = add_en_q & sel_q;

  assign weight_ready = (state_q != S_RUN);
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign out_valid    = out_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= C_SEED;
      sel_q       <= 1'b0;
      add_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      weight_q    <= '0;
    end else begin
      // Loads are only accepted outside RUN; a request during RUN is dropped.
      if (weight_valid && (state_q != S_RUN)) begin
        weight_q <= weight_val;
      end
      if (w_start) begin
        state_q     <= S_RUN;
        lfsr_q      <= C_SEED;
        sel_q       <= 1'b0;
        add_en_q    <= add_en;
        out_valid_q <= 1'b0;
      end else if (w_step) begin
        lfsr_q      <= lfsr_d;
        sel_q       <= ~sel_q;
        out_valid_q <= 1'b1;
        // The LFSR returns to its seed after exactly one full period.
        if (lfsr_d == C_SEED) begin
          state_q <= S_DONE;
        end
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int ROT = gi % BIN_LEN;

    logic [BIN_LEN-1:0] lfsr_rot;
    logic [BIN_LEN-1:0] weight_lane;
    logic               sng;
    logic               pick_x;
    logic               pick_y;
    logic               ox_q;
    logic               oy_q;

    // Per-lane rotation decorrelates lanes that share one LFSR.
    if (ROT == 0) begin : g_rot0
      assign lfsr_rot = lfsr_q;
    end else begin : g_rotn
      assign lfsr_rot = {lfsr_q[BIN_LEN-1-ROT:0], lfsr_q[BIN_LEN-1:BIN_LEN-ROT]};
    end

    assign weight_lane = weight_q[gi*BIN_LEN +: BIN_LEN];
    assign sng         = (lfsr_rot <= weight_lane);
    // The weight's y-stream is constant 1, so the product y is the input y.
    assign pick_x      = w_use_init ? init_val_x[gi] : (sng & input_val_x[gi]);
    assign pick_y      = w_use_init ? init_val_y[gi] : input_val_y[gi];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        ox_q <= 1'b0;
        oy_q <= 1'b0;
      end else if (w_step) begin
        ox_q <= pick_x;
        oy_q <= pick_y;
      end
    end

    assign output_val_x[gi] = ox_q;
    assign output_val_y[gi] = oy_q;

`ifdef ESL_PE_COUNT_EN
    logic [BIN_LEN-1:0] cx_q;
    logic [BIN_LEN-1:0] cy_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (w_start) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (w_step) begin
        cx_q <= cx_q + {{(BIN_LEN-1){1'b0}}, pick_x};
        cy_q <= cy_q + {{(BIN_LEN-1){1'b0}}, pick_y};
      end
    end

    assign cnt_x[gi*BIN_LEN +: BIN_LEN] = cx_q;
    assign cnt_y[gi*BIN_LEN +: BIN_LEN] = cy_q;
`endif
  end

`ifndef ESL_PE_COUNT_EN
  assign cnt_x = '0;
  assign cnt_y = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_esl_pe_vector.sv
`default_nettype none
// ============================================================================
// Module   : tb_esl_pe_vector
// Purpose  : Self-checking bench for esl_pe_vector, LANES = 4, BIN_LEN = 4.
//            Expected stream bits are pushed to a scoreboard when inputs are
//            driven and popped when the registered outputs appear. Count
//            expectations are 0 when ESL_PE_COUNT_EN is undefined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esl_pe_vector;
  localparam int LANES = 4;
  localparam int BL    = 4;
  localparam int W     = LANES * BL;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          weight_valid;
  logic          weight_ready;
  logic [W-1:0]  weight_val;
  logic          add_en;
  logic          start;
  logic [3:0]    input_val_x, input_val_y, init_val_x, init_val_y;
  logic [3:0]    output_val_x, output_val_y;
  logic          out_valid, busy, done;
  logic [W-1:0]  cnt_x, cnt_y;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    sb[$];
  int            mw[4];
  int            mcx[4];
  int            mcy[4];
  logic [3:0]    last_x, last_y;
  // x^4+x^3+1 sequence from seed 1.
  int            seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  esl_pe_vector #(.LANES(LANES), .BIN_LEN(BL), .SEED(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .weight_val   (weight_val),
    .add_en       (add_en),
    .start        (start),
    .input_val_x  (input_val_x),
    .input_val_y  (input_val_y),
    .init_val_x   (init_val_x),
    .init_val_y   (init_val_y),
    .output_val_x (output_val_x),
    .output_val_y (output_val_y),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done),
    .cnt_x        (cnt_x),
    .cnt_y        (cnt_y)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] cexp(input logic [W-1:0] v);
`ifdef ESL_PE_COUNT_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  function automatic logic [W-1:0] model_cnt(input bit y);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*BL +: BL] = y ? 4'(mcy[l]) : 4'(mcx[l]);
    return r;
  endfunction

  function automatic int rotl4(input int v, input int r);
    return ((v << r) | (v >> (4 - r))) & 15;
  endfunction

  task automatic set_w(input logic [W-1:0] v);
    for (int l = 0; l < LANES; l++) mw[l] = int'(v[l*BL +: BL]);
  endtask

  task automatic load_w(input logic [W-1:0] v);
    weight_valid = 1'b1;
    weight_val   = v;
    set_w(v);
    tick;
    weight_valid = 1'b0;
  endtask

  task automatic do_run(input logic addv, input logic [3:0] ix, input logic [3:0] iy,
                        input logic [3:0] nx, input logic [3:0] ny, input bit rnd,
                        input int stall_k, input int wv_k, input bit ld,
                        input logic [W-1:0] wnew, input logic [W-1:0] ecx,
                        input logic [W-1:0] ecy);
    logic [3:0] ex, ey;
    logic [7:0] got;
    start  = 1'b1;
    add_en = addv;
    if (ld) begin
      weight_valid = 1'b1;
      weight_val   = wnew;
      set_w(wnew);
    end
    tick;
    start        = 1'b0;
    weight_valid = 1'b0;
    add_en       = ~addv;  // must have been latched at start
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_wready", weight_ready, 0);
    chk("start_cnt_x", cnt_x, 0);
    chk("start_cnt_y", cnt_y, 0);
    for (int l = 0; l < LANES; l++) begin
      mcx[l] = 0;
      mcy[l] = 0;
    end
    for (int k = 0; k < 15; k++) begin
      if (k == stall_k) begin
        enable = 1'b0;
        repeat (3) begin
          tick;
          chk("stall_out_x", output_val_x, last_x);
          chk("stall_out_y", output_val_y, last_y);
          chk("stall_done", done, 0);
          chk("stall_cnt_x", cnt_x, cexp(model_cnt(0)));
        end
        enable = 1'b1;
      end
      if (k == wv_k) begin
        weight_valid = 1'b1;
        weight_val   = 16'h1234;
        chk("run_wready", weight_ready, 0);
      end
      if (rnd) begin
        ix = 4'($urandom);
        iy = 4'($urandom);
        nx = 4'($urandom);
        ny = 4'($urandom);
      end
      input_val_x = ix;
      input_val_y = iy;
      init_val_x  = nx;
      init_val_y  = ny;
      for (int l = 0; l < LANES; l++) begin
        if (addv && (k % 2 == 1)) begin
          ex[l] = nx[l];
          ey[l] = ny[l];
        end else begin
          ex[l] = ((rotl4(seq[k], l) <= mw[l]) && ix[l]) ? 1'b1 : 1'b0;
          ey[l] = iy[l];
        end
        mcx[l] += int'(ex[l]);
        mcy[l] += int'(ey[l]);
      end
      sb.push_back({ex, ey});
      tick;
      weight_valid = 1'b0;
      got    = sb.pop_front();
      last_x = got[7:4];
      last_y = got[3:0];
      chk("out_x", output_val_x, got[7:4]);
      chk("out_y", output_val_y, got[3:0]);
      chk("done_edge", done, (k == 14) ? 1 : 0);
    end
    chk("final_cnt_x", cnt_x, cexp(rnd ? model_cnt(0) : ecx));
    chk("final_cnt_y", cnt_y, cexp(rnd ? model_cnt(1) : ecy));
    chk("final_busy", busy, 0);
    chk("final_wready", weight_ready, 1);
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b1;
    weight_valid = 1'b0;
    weight_val   = '0;
    add_en       = 1'b0;
    start        = 1'b0;
    input_val_x  = '0;
    input_val_y  = '0;
    init_val_x   = '0;
    init_val_y   = '0;
    last_x       = '0;
    last_y       = '0;
    repeat (2) tick;
    chk("rst_out_x", output_val_x, 0);
    chk("rst_out_y", output_val_y, 0);
    chk("rst_cnt_x", cnt_x, 0);
    chk("rst_cnt_y", cnt_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_wready", weight_ready, 1);
    reset = 1'b1;
    tick;

    // Full weight, product vs zero init: 8 product picks.
    load_w(16'hFFFF);
    do_run(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 0, -1, -1, 0, '0, 16'h8888, 16'h8888);
    // Back-to-back: start in the first DONE cycle.
    do_run(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 0, -1, -1, 0, '0, 16'h8888, 16'h8888);

    // Zero weight, init (1,1): 7 init picks on x, all ones on y.
    load_w(16'h0000);
    do_run(1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 0, -1, -1, 0, '0, 16'h7777, 16'hFFFF);

    // Mixed weights {5,0,9,15}, product only.
    load_w(16'hF905);
    do_run(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 0, -1, -1, 0, '0, 16'hF905, 16'hFFFF);
    // Same with a 3-cycle enable-low stall mid-run.
    do_run(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 7, -1, 0, '0, 16'hF905, 16'hFFFF);

    // Reset at RUN cycle 7.
    start  = 1'b1;
    tick;
    start  = 1'b0;
    repeat (7) tick;
    reset = 1'b0;
    #2;
    chk("mid_rst_cnt_x", cnt_x, 0);
    chk("mid_rst_cnt_y", cnt_y, 0);
    chk("mid_rst_out_x", output_val_x, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_wready", weight_ready, 1);
    #1;
    reset = 1'b1;
    tick;
    // Weights were cleared by reset; the RUN-time load must be ignored.
    set_w(16'h0000);
    do_run(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 0, -1, 3, 0, '0, 16'h0000, 16'hFFFF);

    // Random streams with a weight load coinciding with start.
    repeat (2) begin
      do_run(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1, -1, -1, 1, 16'($urandom), '0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
